// File: rtl/tick_delay_pkg.sv
// Shared types and helpers for the tick delay scheduler.
// The state enum, default parameter values and the round-robin index helpers.
package tick_delay_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DIV_DEFAULT = 250000;
    localparam int CW_DEFAULT  = 8;
    localparam int NREQ_MAX    = 8;

    // First set bit of req_vec scanning upward from ptr, wrapping at n.
    // The caller only uses the result when req_vec has at least one bit set.
    function automatic logic [2:0] rr_pick(input logic [NREQ_MAX-1:0] req_vec,
                                           input logic [2:0]          ptr,
                                           input int                  n);
        logic [2:0] pick;
        logic       hit;
        int         idx;
        pick = 3'd0;
        hit  = 1'b0;
        for (int k = 0; k < NREQ_MAX; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !hit && req_vec[idx[2:0]]) begin
                pick = idx[2:0];
                hit  = 1'b1;
            end
        end
        return pick;
    endfunction

    // Pointer value after serving idx: the slot just above it, wrapping at n.
    function automatic logic [2:0] rr_inc(input logic [2:0] idx, input int n);
        return (int'(idx) + 1 == n) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/tick_delay_scheduler_tick_gen.sv
// Slow-tick prescaler for the tick delay scheduler.
// Counts 0..DIV-1 while enabled and emits a single-cycle tick on DIV-1.
// A clear restarts the phase so ticks are measured from the owner's grant.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    // Next prescaler value: clear wins, otherwise advance and wrap on tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + PW'(1);
        end
    end

    // Prescaler register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tick_delay_scheduler.sv
// Shared one-shot delay engine: round-robin arbiter plus countdown FSM.
// Requesters ask for N slow ticks; the winner gets a grant pulse and later a
// done pulse exactly N*DIV+1 cycles after the grant.
// Optional build macro TICK_DELAY_SCHED_ABORT_EN adds an abort input that
// cancels the owner's countdown without a done pulse.
//
// state | meaning
// IDLE  | engine free; arbitrate and grant in the same cycle
// COUNT | counting slow ticks for owner
// DONE  | one-cycle done pulse to owner, then back to IDLE
module tick_delay_scheduler
    import tick_delay_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DIV  = DIV_DEFAULT,
    parameter int CW   = CW_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*CW-1:0]        delay,
    output logic [NREQ-1:0]           grant,
    output logic [NREQ-1:0]           done,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   owner
`ifdef TICK_DELAY_SCHED_ABORT_EN
    ,
    input  logic [NREQ-1:0]           abort
`endif
);

    localparam int OW = $clog2(NREQ);

    state_e        state_q, state_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] ptr_q, ptr_d;
    logic [OW-1:0] pick;
    logic [CW-1:0] pick_delay;
    logic          tick;
    logic          tick_clr;
    logic          tick_en;
    logic          abort_hit;

    assign pick       = OW'(rr_pick(NREQ_MAX'(req), 3'(ptr_q), NREQ));
    assign pick_delay = delay[pick*CW +: CW];
    assign tick_en    = (state_q == COUNT);
    assign owner      = owner_q;

`ifdef TICK_DELAY_SCHED_ABORT_EN
    assign abort_hit = (state_q == COUNT) && abort[owner_q];
`else
    assign abort_hit = 1'b0;
`endif

    tick_gen #(
        .DIV(DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr_i (tick_clr),
        .en_i  (tick_en),
        .tick_o(tick)
    );

    // Arbitration, countdown and output decode.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        tick_clr = 1'b0;
        grant    = '0;
        done     = '0;
        busy     = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                // Grant is decoded here so the grant cycle is the arbitration
                // cycle; gating with reset keeps outputs quiet during reset.
                if (!reset && (|req)) begin
                    grant[pick] = 1'b1;
                    owner_d     = pick;
                    ptr_d       = OW'(rr_inc(3'(pick), NREQ));
                    rem_d       = pick_delay;
                    tick_clr    = 1'b1;
                    state_d     = (pick_delay == '0) ? DONE : COUNT;
                end
            end
            COUNT: begin
                // Abort beats a coincident final tick.
                if (abort_hit) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (rem_q == CW'(1)) begin
                        state_d = DONE;
                    end else begin
                        rem_d = rem_q - CW'(1);
                    end
                end
            end
            DONE: begin
                done[owner_q] = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, countdown, owner and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule
